fb_scanout_arbiter: RTL and testbench

- Owns the single-port framebuffer RAM and shares it between two requesters: the display scanout fetch and the pixel writer (emulated PPU).
- Contains a line-fetch sequencer. Each line request from the display timing side makes it read one line of pixels and stream them to the downstream line FIFO.
- Arbitrates each cycle between scanout reads and writer writes, using urgency, anti-starvation and round-robin rules.
- Sits between the pixel writer, the framebuffer RAM, and the line FIFO that feeds the display timing generator.

---
 rtl/fb_scanout_arbiter.sv | 165 ++++++++++++++++
 tb/tb_fb_scanout_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout_arbiter.sv
// rtl/fb_scanout_arbiter.sv - framebuffer RAM owner arbitrating scanout line fetch against pixel writer
module fb_scanout_arbiter #(
    parameter int WIDTH    = 160,
    parameter int HEIGHT   = 144,
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    input  logic              i_line_req,
    input  logic              i_fifo_low,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_pix_valid,
    output logic [DATA_W-1:0] o_pix_data,
    output logic              o_line_overrun,
    output logic              o_busy
);
    localparam int COL_W  = $clog2(WIDTH);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

    typedef enum logic {S_IDLE, S_FETCH} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_faddr;
    logic [COL_W-1:0]  r_col;
    logic              r_pending;
    logic [WAIT_W-1:0] r_wait;
    logic              r_last_wr;
    logic              r_rd_v1;
    logic              r_rd_v2;

    logic w_rd_req;
    logic w_rd_grant;
    logic w_wr_grant;
    logic w_rd_take;
    logic w_last_col;

    assign w_rd_req = (r_state == S_FETCH);

    always_comb begin
        w_rd_grant = 1'b0;
        w_wr_grant = 1'b0;
        if (w_rd_req && i_wr_req) begin
            if (i_fifo_low)
                w_rd_grant = 1'b1;
            else if (r_wait == WAIT_MAX)
                w_wr_grant = 1'b1;
            else if (r_last_wr)
                w_rd_grant = 1'b1;
            else
                w_wr_grant = 1'b1;
        end else begin
            w_rd_grant = w_rd_req;
            w_wr_grant = i_wr_req;
        end
    end

    // A read granted on a frame_start edge is thrown away, not issued.
    assign w_rd_take  = w_rd_grant & ~i_frame_start;
    assign w_last_col = (r_col == LAST_COL);
    assign o_wr_ready = w_wr_grant & i_rst_n;
    assign o_busy     = (r_state == S_FETCH);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_faddr        <= '0;
            r_col          <= '0;
            r_pending      <= 1'b0;
            r_wait         <= '0;
            r_last_wr      <= 1'b1;
            r_rd_v1        <= 1'b0;
            r_rd_v2        <= 1'b0;
            o_mem_en       <= 1'b0;
            o_mem_we       <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_wdata    <= '0;
            o_pix_valid    <= 1'b0;
            o_pix_data     <= '0;
            o_line_overrun <= 1'b0;
        end else begin
            if (w_wr_grant) begin
                o_mem_en    <= 1'b1;
                o_mem_we    <= 1'b1;
                o_mem_addr  <= i_wr_addr;
                o_mem_wdata <= i_wr_data;
            end else if (w_rd_take) begin
                o_mem_en   <= 1'b1;
                o_mem_we   <= 1'b0;
                o_mem_addr <= r_faddr;
            end else begin
                o_mem_en <= 1'b0;
                o_mem_we <= 1'b0;
            end

            if (w_wr_grant || w_rd_take)
                r_last_wr <= w_wr_grant;

            if (w_wr_grant)
                r_wait <= '0;
            else if (i_wr_req && r_wait != WAIT_MAX)
                r_wait <= r_wait + WAIT_W'(1);

            // RAM returns data one cycle after the strobe; pixel is registered one cycle later.
            r_rd_v1     <= w_rd_take;
            r_rd_v2     <= r_rd_v1;
            o_pix_valid <= r_rd_v2;
            if (r_rd_v2)
                o_pix_data <= i_mem_rdata;

            if (i_frame_start) begin
                r_state        <= S_IDLE;
                r_faddr        <= '0;
                r_col          <= '0;
                r_pending      <= 1'b0;
                o_line_overrun <= 1'b0;
                r_rd_v1        <= 1'b0;
                r_rd_v2        <= 1'b0;
                o_pix_valid    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_line_req || r_pending) begin
                            r_state   <= S_FETCH;
                            r_col     <= '0;
                            r_pending <= r_pending & i_line_req;
                        end
                    end
                    S_FETCH: begin
                        if (w_rd_take) begin
                            r_faddr <= (r_faddr == LAST_ADDR) ? '0 : r_faddr + ADDR_W'(1);
                            r_col   <= r_col + COL_W'(1);
                        end
                        if (w_rd_take && w_last_col) begin
                            r_col <= '0;
                            if (r_pending || i_line_req)
                                r_pending <= r_pending & i_line_req;
                            else
                                r_state <= S_IDLE;
                        end else if (i_line_req) begin
                            if (!r_pending)
                                r_pending <= 1'b1;
                            else
                                o_line_overrun <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// tb/tb_fb_scanout_arbiter.sv - scoreboard bench for fb_scanout_arbiter
module tb_fb_scanout_arbiter;
    localparam int FRAME = 160 * 144;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        line_req = 1'b0;
    logic        fifo_low = 1'b0;
    logic        wr_req = 1'b0;
    logic [14:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ready;
    logic        mem_en;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        line_overrun;
    logic        busy;

    int checks = 0;
    int failures = 0;

    logic [15:0] ram     [0:32767];
    logic [15:0] exp_mem [0:32767];
    logic [15:0] pq[$];
    logic [30:0] wq[$];

    fb_scanout_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start), .i_line_req(line_req),
        .i_fifo_low(fifo_low), .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_wr_ready(wr_ready), .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_pix_valid(pix_valid),
        .o_pix_data(pix_data), .o_line_overrun(line_overrun), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pix_valid) begin
                if (pq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pix actual=%h required=none", pix_data);
                end else begin
                    check("pix_data", {16'h0, pix_data}, {16'h0, pq.pop_front()});
                end
            end
            if (mem_en && mem_we) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%h/%h required=none", mem_addr, mem_wdata);
                end else begin
                    check("mem_write", {1'b0, mem_addr, mem_wdata}, {1'b0, wq.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_line();
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic push_line(input int base);
        for (int i = 0; i < 160; i++)
            pq.push_back(exp_mem[(base + i) % FRAME]);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((pq.size() != 0 || wq.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        check("drain", pq.size() + wq.size(), 0);
    endtask

    task automatic writer(input int n, input logic [14:0] base, output int max_wait);
        max_wait = 0;
        for (int i = 0; i < n; i++) begin
            int w = 0;
            wr_req  = 1'b1;
            wr_addr = base + 15'(i);
            wr_data = 16'hC000 ^ 16'(i);
            wq.push_back({wr_addr, wr_data});
            exp_mem[wr_addr] = wr_data;
            forever begin
                @(negedge clk);
                if (wr_ready) begin
                    tick();
                    break;
                end
                w++;
                tick();
                if (w > 1000) begin
                    check("write_timeout", 32'(w), 0);
                    break;
                end
            end
            if (w > max_wait) max_wait = w;
        end
        wr_req = 1'b0;
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int mw;
        for (int a = 0; a < 32768; a++) begin
            ram[a]     = {a[14:0], 1'b0} ^ 16'h5A3C;
            exp_mem[a] = {a[14:0], 1'b0} ^ 16'h5A3C;
        end
        repeat (3) tick();
        check("reset_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
        check("reset_misc", {wr_ready, pix_valid, pix_data, line_overrun, busy}, 0);
        rst_n = 1'b1;
        tick();

        // line fetch, no contention
        pulse_frame();
        push_line(0);
        pulse_line();
        check("busy_start", busy, 1);
        tick();
        tick();
        check("pix_lat_l2", pix_valid, 0);
        tick();
        check("pix_lat_l3", pix_valid, 1);
        repeat (156) tick();
        check("busy_l159", busy, 1);
        tick();
        check("busy_l160", busy, 0);
        wait_drain(50);

        // alternating grants
        pulse_frame();
        push_line(0);
        fork
            writer(170, 15'h6000, mw);
            begin
                pulse_line();
                repeat (318) tick();
                check("alt_busy_l318", busy, 1);
                tick();
                check("alt_busy_l319", busy, 0);
            end
        join
        check("alt_max_wait", 32'(mw), 1);
        wait_drain(50);

        // urgent scanout starves writes
        pulse_frame();
        fifo_low = 1'b1;
        push_line(0);
        fork
            writer(3, 15'h7000, mw);
            begin
                pulse_line();
                repeat (159) tick();
                check("urg_busy_l159", busy, 1);
                tick();
                check("urg_busy_l160", busy, 0);
            end
        join
        check("urg_max_wait", 32'(mw), 160);
        fifo_low = 1'b0;
        wait_drain(50);
        wr_req  = 1'b1;
        wr_addr = 15'h1234;
        wr_data = 16'hF800;
        wq.push_back({15'h1234, 16'hF800});
        exp_mem[15'h1234] = 16'hF800;
        @(negedge clk);
        check("wr_ready_idle", wr_ready, 1);
        tick();
        wr_req = 1'b0;
        check("w1234_en_we", {mem_en, mem_we}, 2'b11);
        check("w1234_addr", mem_addr, 15'h1234);
        check("w1234_data", mem_wdata, 16'hF800);
        wait_drain(20);

        // pending and overrun
        pulse_frame();
        push_line(0);
        push_line(160);
        pulse_line();
        repeat (9) tick();
        pulse_line();
        check("ovr_after_2nd", line_overrun, 0);
        repeat (9) tick();
        pulse_line();
        check("ovr_after_3rd", line_overrun, 1);
        repeat (299) tick();
        check("b2b_busy_l319", busy, 1);
        tick();
        check("b2b_busy_l320", busy, 0);
        wait_drain(50);
        check("ovr_sticky", line_overrun, 1);
        pulse_frame();
        check("ovr_cleared", line_overrun, 0);

        // abort mid-line: only reads three or more edges before frame_start show up
        push_line(0);
        repeat (112) void'(pq.pop_back());
        pulse_line();
        repeat (50) tick();
        pulse_frame();
        check("abort_busy", busy, 0);
        repeat (10) tick();
        check("abort_drained", pq.size(), 0);
        push_line(0);
        pulse_line();
        wait_drain(400);

        // full frame plus wrap
        pulse_frame();
        for (int l = 0; l <= 144; l++) begin
            push_line(l * 160);
            pulse_line();
            repeat (163) tick();
        end
        wait_drain(50);

        // async reset mid-fetch
        pulse_frame();
        push_line(0);
        pulse_line();
        repeat (30) tick();
        wr_req = 1'b1;
        rst_n  = 1'b0;
        #1;
        check("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
        check("rst_misc", {wr_ready, pix_valid, pix_data, line_overrun, busy}, 0);
        pq.delete();
        wq.delete();
        tick();
        wr_req = 1'b0;
        rst_n  = 1'b1;
        repeat (5) tick();
        check("post_rst_idle", {busy, pix_valid, mem_en}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
